// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM; optional addi support under `MC_ADDI_EN.
// Latency: R 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEMRD/MEMWR until mem_ready; aborts after WAIT_MAX wait cycles.
module mc_main_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam int            CW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam bit            TO_EN     = (WAIT_MAX > 0);
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_wait      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        mem_err       = 1'b0;

        case (state_q)
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                mem_wait = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                mem_wait  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            // FETCH, plus any encoding with no state of its own
            default: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                mem_wait  = 1'b1;
                if (mem_ready) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
        endcase

        // A completing access always beats the timeout in the same cycle.
        if (mem_wait && !mem_ready) begin
            if (TO_EN && (wait_cnt_q == WAIT_LAST)) begin
                mem_err    = 1'b1;
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end else if (TO_EN) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_src        = 2'b00;
            alu_op        = 2'b00;
            instr_done    = 1'b0;
            illegal       = 1'b0;
            mem_err       = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: walks each instruction class cycle by cycle against hand-written strobe vectors.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;
    logic       instr_done, illegal, mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_main_ctrl #(.WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .state        (state),
        .instr_done   (instr_done),
        .illegal      (illegal),
        .mem_err      (mem_err)
    );

    // Observed control word, MSB first
    logic [18:0] ctl_obs;
    assign ctl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
                      alu_op, instr_done, illegal, mem_err};

    localparam logic [18:0] PCW     = 19'd1 << 18;
    localparam logic [18:0] PCWC    = 19'd1 << 17;
    localparam logic [18:0] IORD    = 19'd1 << 16;
    localparam logic [18:0] MRD     = 19'd1 << 15;
    localparam logic [18:0] MWR     = 19'd1 << 14;
    localparam logic [18:0] IRW     = 19'd1 << 13;
    localparam logic [18:0] M2R     = 19'd1 << 12;
    localparam logic [18:0] RDST    = 19'd1 << 11;
    localparam logic [18:0] RW      = 19'd1 << 10;
    localparam logic [18:0] ASA     = 19'd1 << 9;
    localparam logic [18:0] ASB_4   = 19'd1 << 7;
    localparam logic [18:0] ASB_IMM = 19'd2 << 7;
    localparam logic [18:0] ASB_SH  = 19'd3 << 7;
    localparam logic [18:0] PCS_OUT = 19'd1 << 5;
    localparam logic [18:0] PCS_J   = 19'd2 << 5;
    localparam logic [18:0] AOP_SUB = 19'd1 << 3;
    localparam logic [18:0] AOP_F   = 19'd2 << 3;
    localparam logic [18:0] DONE    = 19'd1 << 2;
    localparam logic [18:0] ILL     = 19'd1 << 1;
    localparam logic [18:0] ERR     = 19'd1;

    localparam logic [18:0] E_FETCH_RDY  = PCW | MRD | IRW | ASB_4;
    localparam logic [18:0] E_FETCH_WAIT = MRD | ASB_4;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check state/control word for the current cycle, then move to just after the next edge.
    task automatic step(input string tag, input logic [3:0] exp_state, input logic [18:0] exp_ctl);
        #1;
        check_eq({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
        check_eq({tag, "_ctl"}, {13'd0, ctl_obs}, {13'd0, exp_ctl});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        @(posedge clk);
        #1;
        check_eq("rst_state", {28'd0, state}, 32'd0);
        check_eq("rst_ctl", {13'd0, ctl_obs}, 32'd0);
        mem_ready = 1'b1;
        #1;
        check_eq("rst_ctl_rdy", {13'd0, ctl_obs}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type, zero wait
        opcode = 6'b000000;
        step("r_fetch", 4'd0, E_FETCH_RDY);
        step("r_dec",   4'd1, ASB_SH);
        step("r_exec",  4'd6, ASA | AOP_F);
        step("r_rwb",   4'd7, RW | RDST | DONE);

        // lw with three wait cycles in MEMRD
        opcode = 6'b100011;
        step("lw_fetch", 4'd0, E_FETCH_RDY);
        step("lw_dec",   4'd1, ASB_SH);
        step("lw_adr",   4'd2, ASA | ASB_IMM);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 4'd3, MRD | IORD);
        mem_ready = 1'b1;
        step("lw_rd",    4'd3, MRD | IORD);
        step("lw_wb",    4'd4, RW | M2R | DONE);

        // beq
        opcode = 6'b000100;
        step("beq_fetch", 4'd0, E_FETCH_RDY);
        step("beq_dec",   4'd1, ASB_SH);
        step("beq_br",    4'd8, ASA | AOP_SUB | PCWC | PCS_OUT | DONE);

        // j
        opcode = 6'b000010;
        step("j_fetch", 4'd0, E_FETCH_RDY);
        step("j_dec",   4'd1, ASB_SH);
        step("j_jump",  4'd9, PCW | PCS_J | DONE);

        // unsupported opcode
        opcode = 6'b111111;
        step("ill_fetch", 4'd0, E_FETCH_RDY);
        step("ill_dec",   4'd1, ASB_SH | ILL | DONE);

        // sw with a hung memory: abort after 15 MEMWR cycles
        opcode = 6'b101011;
        step("swto_fetch", 4'd0, E_FETCH_RDY);
        step("swto_dec",   4'd1, ASB_SH);
        step("swto_adr",   4'd2, ASA | ASB_IMM);
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) step("swto_wr_wait", 4'd5, MWR | IORD);
        step("swto_wr_err", 4'd5, MWR | IORD | ERR);

        // hung fetch: abort after 15 cycles and restart the count
        for (int i = 0; i < 14; i++) step("fto_wait", 4'd0, E_FETCH_WAIT);
        step("fto_err",   4'd0, E_FETCH_WAIT | ERR);
        step("fto_after", 4'd0, E_FETCH_WAIT);
        mem_ready = 1'b1;

        // sw where mem_ready arrives on the would-be timeout cycle
        step("swrw_fetch", 4'd0, E_FETCH_RDY);
        step("swrw_dec",   4'd1, ASB_SH);
        step("swrw_adr",   4'd2, ASA | ASB_IMM);
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) step("swrw_wait", 4'd5, MWR | IORD);
        mem_ready = 1'b1;
        step("swrw_done", 4'd5, MWR | IORD | DONE);

        // addi
        opcode = 6'b001000;
        step("addi_fetch", 4'd0, E_FETCH_RDY);
`ifdef MC_ADDI_EN
        step("addi_dec", 4'd1, ASB_SH);
        step("addi_ex",  4'd10, ASA | ASB_IMM);
        step("addi_wb",  4'd11, RW | DONE);
`else
        step("addi_dec_ill", 4'd1, ASB_SH | ILL | DONE);
`endif

        // reset while in MEMWB suppresses the register write
        opcode = 6'b100011;
        step("lwr_fetch", 4'd0, E_FETCH_RDY);
        step("lwr_dec",   4'd1, ASB_SH);
        step("lwr_adr",   4'd2, ASA | ASB_IMM);
        step("lwr_rd",    4'd3, MRD | IORD);
        rst = 1'b1;
        step("lwr_wb_rst", 4'd4, 19'd0);
        step("lwr_in_rst", 4'd0, 19'd0);
        rst = 1'b0;
        opcode = 6'b000000;
        step("post_fetch", 4'd0, E_FETCH_RDY);
        step("post_dec",   4'd1, ASB_SH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
